// File: rtl/cmd_executor.sv
// Runs one buffered command as a train of timed impulses with optional linear chirp.
// Keeps a one-deep shadow command and asks the writer for the next one through REQ_COMM.
module cmd_executor #(
  parameter int REQ_LEN     = 4,
  parameter int REQ_TIMEOUT = 4800
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic [63:0] TIME,
  input  logic        SYS_TIME_UPDATE,
  input  logic        DATA_WR,
  input  logic [47:0] FREQ_z,
  input  logic [47:0] FREQ_STEP_z,
  input  logic [31:0] FREQ_RATE_z,
  input  logic [63:0] TIME_START_z,
  input  logic [15:0] N_impuls_z,
  input  logic [1:0]  TYPE_impulse_z,
  input  logic [31:0] Interval_Ti_z,
  input  logic [31:0] Interval_Tp_z,
  input  logic [31:0] Tblank1_z,
  input  logic [31:0] Tblank2_z,
  output logic        REQ_COMM,
  output logic        IMP,
  output logic        BLANK,
  output logic [47:0] FREQ_OUT,
  output logic        BUSY,
  output logic [15:0] IMP_CNT,
  output logic        CMD_ERR
);

  typedef struct packed {
    logic [47:0] freq;
    logic [47:0] step;
    logic [31:0] rate;
    logic [63:0] tstart;
    logic [15:0] n;
    logic [1:0]  typ;
    logic [31:0] ti;
    logic [31:0] tp;
    logic [31:0] tb1;
    logic [31:0] tb2;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, WAIT, RUN} exec_t;
  typedef enum logic [1:0] {REQ_IDLE, REQ_HIGH, REQ_WAIT, REQ_LOW} req_t;

  cmd_t        wr_cmd, pend, act;
  logic        pend_valid;
  logic [1:0]  dwr_sync, stu_sync;
  logic        cap, abort, load, bad_cmd;
  exec_t       state;
  req_t        rstate;
  logic [31:0] phase, next_phase, step_cnt, req_cnt;
  logic        period_end, next_imp, next_blank, chirp, chirp_tick;
  logic [32:0] blank_hi, blank_lo;

  assign wr_cmd = '{freq: FREQ_z, step: FREQ_STEP_z, rate: FREQ_RATE_z, tstart: TIME_START_z,
                    n: N_impuls_z, typ: TYPE_impulse_z, ti: Interval_Ti_z, tp: Interval_Tp_z,
                    tb1: Tblank1_z, tb2: Tblank2_z};

  assign cap     = dwr_sync[0] & ~dwr_sync[1];
  assign abort   = stu_sync[0] & ~stu_sync[1];
  assign load    = (state == IDLE) && pend_valid;
  assign bad_cmd = (pend.tstart <= TIME) || (pend.tp == 32'd0) || (pend.n == 16'd0);
  assign BUSY    = (state != IDLE);

  // Outputs are registered from the phase they will show, so IMP/BLANK track p with no lag.
  assign period_end = (phase == act.tp - 32'd1);
  assign next_phase = (state == RUN && !period_end) ? phase + 32'd1 : 32'd0;
  assign blank_hi   = {1'b0, act.ti} + {1'b0, act.tb1};
  assign blank_lo   = (act.tp >= act.tb2) ? {1'b0, act.tp - act.tb2} : 33'd0;
  assign next_imp   = next_phase < act.ti;
  assign next_blank = ({1'b0, next_phase} < blank_hi) || ({1'b0, next_phase} >= blank_lo);
  assign chirp      = (act.typ == 2'd1) || (act.typ == 2'd2);
  assign chirp_tick = (act.rate <= 32'd1) || (step_cnt == act.rate - 32'd1);

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      dwr_sync <= '0;
      stu_sync <= '0;
    end else begin
      dwr_sync <= {dwr_sync[0], DATA_WR};
      stu_sync <= {stu_sync[0], SYS_TIME_UPDATE};
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pend       <= '0;
      act        <= '0;
      pend_valid <= 1'b0;
      phase      <= '0;
      step_cnt   <= '0;
      IMP        <= 1'b0;
      BLANK      <= 1'b0;
      FREQ_OUT   <= '0;
      IMP_CNT    <= '0;
      CMD_ERR    <= 1'b0;
    end else begin
      CMD_ERR <= 1'b0;
      if (abort) begin
        // Abort also swallows a capture landing in the same cycle.
        state      <= IDLE;
        pend_valid <= 1'b0;
        IMP        <= 1'b0;
        BLANK      <= 1'b0;
      end else begin
        if (cap) begin
          pend       <= wr_cmd;
          pend_valid <= 1'b1;
          if (pend_valid && !load) CMD_ERR <= 1'b1;
        end else if (load) begin
          pend_valid <= 1'b0;
        end
        case (state)
          IDLE: if (load) begin
            act <= pend;
            if (bad_cmd) CMD_ERR <= 1'b1;
            else         state   <= WAIT;
          end
          WAIT: if (TIME >= act.tstart) begin
            state    <= RUN;
            phase    <= '0;
            step_cnt <= '0;
            IMP_CNT  <= 16'd1;
            FREQ_OUT <= act.freq;
            IMP      <= next_imp;
            BLANK    <= next_blank;
          end
          RUN: begin
            phase <= next_phase;
            IMP   <= next_imp;
            BLANK <= next_blank;
            if (period_end) begin
              step_cnt <= '0;
              if (IMP_CNT == act.n) begin
                state <= IDLE;
                IMP   <= 1'b0;
                BLANK <= 1'b0;
              end else begin
                IMP_CNT  <= IMP_CNT + 16'd1;
                FREQ_OUT <= act.freq;
              end
            end else if (IMP && chirp) begin
              if (chirp_tick) begin
                step_cnt <= '0;
                FREQ_OUT <= (act.typ == 2'd1) ? FREQ_OUT + act.step : FREQ_OUT - act.step;
              end else begin
                step_cnt <= step_cnt + 32'd1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Request handshake: pulse width and minimum low gap suit the writer's 3-stage edge detector.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      rstate   <= REQ_IDLE;
      req_cnt  <= '0;
      REQ_COMM <= 1'b0;
    end else if (abort) begin
      rstate   <= REQ_HIGH;
      req_cnt  <= '0;
      REQ_COMM <= 1'b1;
    end else begin
      case (rstate)
        REQ_IDLE: if (!pend_valid) begin
          rstate   <= REQ_HIGH;
          req_cnt  <= '0;
          REQ_COMM <= 1'b1;
        end
        REQ_HIGH: if (req_cnt == 32'(REQ_LEN - 1)) begin
          rstate   <= REQ_WAIT;
          req_cnt  <= '0;
          REQ_COMM <= 1'b0;
        end else begin
          req_cnt <= req_cnt + 32'd1;
        end
        REQ_WAIT: if (cap) begin
          rstate <= REQ_IDLE;
        end else if (req_cnt == 32'(REQ_TIMEOUT - 1)) begin
          rstate  <= REQ_LOW;
          req_cnt <= '0;
        end else begin
          req_cnt <= req_cnt + 32'd1;
        end
        REQ_LOW: if (req_cnt == 32'd2) begin
          rstate   <= REQ_HIGH;
          req_cnt  <= '0;
          REQ_COMM <= 1'b1;
        end else begin
          req_cnt <= req_cnt + 32'd1;
        end
        default: rstate <= REQ_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_executor.sv
// Directed bench for cmd_executor: request timing, bursts, chirp, rejects, overwrite, abort.
module tb_cmd_executor;

  logic        CLK, rst;
  logic [63:0] TIME;
  logic        SYS_TIME_UPDATE, DATA_WR;
  logic [47:0] FREQ_z, FREQ_STEP_z;
  logic [31:0] FREQ_RATE_z;
  logic [63:0] TIME_START_z;
  logic [15:0] N_impuls_z;
  logic [1:0]  TYPE_impulse_z;
  logic [31:0] Interval_Ti_z, Interval_Tp_z, Tblank1_z, Tblank2_z;
  logic        REQ_COMM, IMP, BLANK, BUSY, CMD_ERR;
  logic [47:0] FREQ_OUT;
  logic [15:0] IMP_CNT;

  int checks = 0, failures = 0;
  int err_seen = 0, imp_seen = 0, req_rises = 0;
  logic req_prev = 1'b0;

  cmd_executor dut (
    .CLK(CLK), .rst(rst), .TIME(TIME), .SYS_TIME_UPDATE(SYS_TIME_UPDATE), .DATA_WR(DATA_WR),
    .FREQ_z(FREQ_z), .FREQ_STEP_z(FREQ_STEP_z), .FREQ_RATE_z(FREQ_RATE_z),
    .TIME_START_z(TIME_START_z), .N_impuls_z(N_impuls_z), .TYPE_impulse_z(TYPE_impulse_z),
    .Interval_Ti_z(Interval_Ti_z), .Interval_Tp_z(Interval_Tp_z),
    .Tblank1_z(Tblank1_z), .Tblank2_z(Tblank2_z),
    .REQ_COMM(REQ_COMM), .IMP(IMP), .BLANK(BLANK), .FREQ_OUT(FREQ_OUT), .BUSY(BUSY),
    .IMP_CNT(IMP_CNT), .CMD_ERR(CMD_ERR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Advance n cycles; TIME counts one tick per clock and outputs are sampled 1ns after the edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
      TIME = TIME + 64'd1;
      if (CMD_ERR) err_seen++;
      if (IMP) imp_seen++;
      if (REQ_COMM && !req_prev) req_rises++;
      req_prev = REQ_COMM;
    end
  endtask

  task automatic send_cmd(input logic [63:0] ts, input logic [47:0] f, input logic [47:0] st,
                          input logic [31:0] rate, input logic [15:0] n, input logic [1:0] typ,
                          input logic [31:0] ti, input logic [31:0] tp,
                          input logic [31:0] tb1, input logic [31:0] tb2);
    TIME_START_z = ts; FREQ_z = f; FREQ_STEP_z = st; FREQ_RATE_z = rate; N_impuls_z = n;
    TYPE_impulse_z = typ; Interval_Ti_z = ti; Interval_Tp_z = tp; Tblank1_z = tb1; Tblank2_z = tb2;
    DATA_WR = 1'b1;
    tick(2);
    DATA_WR = 1'b0;
    tick(2);
  endtask

  task automatic wait_imp(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      if (IMP === 1'b1) ok = 1'b1;
      else tick(1);
    end
  endtask

  task automatic wait_idle(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      if (BUSY === 1'b0) ok = 1'b1;
      else tick(1);
    end
  endtask

  task automatic test_reset;
    int hi, lo;
    tick(3);
    checks++; if (REQ_COMM !== 1'b0) begin failures++; $display("FAIL rst_req got %b want 0", REQ_COMM); end
    checks++; if (IMP !== 1'b0) begin failures++; $display("FAIL rst_imp got %b want 0", IMP); end
    checks++; if (BLANK !== 1'b0) begin failures++; $display("FAIL rst_blank got %b want 0", BLANK); end
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL rst_busy got %b want 0", BUSY); end
    checks++; if (FREQ_OUT !== 48'd0) begin failures++; $display("FAIL rst_freq got %0d want 0", FREQ_OUT); end
    checks++; if (IMP_CNT !== 16'd0) begin failures++; $display("FAIL rst_cnt got %0d want 0", IMP_CNT); end
    checks++; if (CMD_ERR !== 1'b0) begin failures++; $display("FAIL rst_err got %b want 0", CMD_ERR); end
    rst = 1'b0;
    tick(1);
    hi = 0;
    while (REQ_COMM === 1'b1 && hi < 20) begin hi++; tick(1); end
    checks++; if (hi != 4) begin failures++; $display("FAIL req_high_len got %0d want 4", hi); end
    lo = 0;
    while (REQ_COMM !== 1'b1 && lo < 6000) begin lo++; tick(1); end
    checks++; if (lo != 4803) begin failures++; $display("FAIL req_reissue_gap got %0d want 4803", lo); end
  endtask

  task automatic test_basic_burst;
    bit ok;
    int p;
    TIME = 64'd1000;
    send_cmd(64'd2000, 48'd500, 48'd0, 32'd0, 16'd3, 2'd0, 32'd10, 32'd100, 32'd5, 32'd8);
    wait_imp(2000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL burst_start timeout got IMP=%b want 1", IMP); end
    checks++; if (TIME !== 64'd2001) begin failures++; $display("FAIL burst_start_time got %0d want 2001", TIME); end
    for (int k = 0; k < 300; k++) begin
      p = k % 100;
      checks++; if (IMP !== (p < 10)) begin failures++; $display("FAIL burst_imp k=%0d got %b want %b", k, IMP, p < 10); end
      checks++; if (BLANK !== (p < 15 || p >= 92)) begin failures++; $display("FAIL burst_blank k=%0d got %b want %b", k, BLANK, (p < 15 || p >= 92)); end
      checks++; if (IMP_CNT !== 16'(k / 100 + 1)) begin failures++; $display("FAIL burst_cnt k=%0d got %0d want %0d", k, IMP_CNT, k / 100 + 1); end
      checks++; if (FREQ_OUT !== 48'd500) begin failures++; $display("FAIL burst_freq k=%0d got %0d want 500", k, FREQ_OUT); end
      tick(1);
    end
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL burst_end_busy got %b want 0", BUSY); end
    checks++; if (IMP !== 1'b0 || BLANK !== 1'b0) begin failures++; $display("FAIL burst_end_gates got %b%b want 00", IMP, BLANK); end
    checks++; if (IMP_CNT !== 16'd3) begin failures++; $display("FAIL burst_end_cnt got %0d want 3", IMP_CNT); end
  endtask

  task automatic test_chirp;
    bit ok;
    int p;
    logic [47:0] exp_f;
    send_cmd(TIME + 64'd10, 48'd1000, 48'd5, 32'd2, 16'd2, 2'd1, 32'd10, 32'd20, 32'd0, 32'd0);
    wait_imp(100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL chirp_up_start timeout got IMP=%b want 1", IMP); end
    for (int k = 0; k < 40; k++) begin
      p = k % 20;
      if (p < 10) begin
        exp_f = 48'd1000 + 48'(5 * (p / 2));
        checks++; if (FREQ_OUT !== exp_f) begin failures++; $display("FAIL chirp_up k=%0d got %0d want %0d", k, FREQ_OUT, exp_f); end
      end
      tick(1);
    end
    wait_idle(50, ok);
    checks++; if (!ok) begin failures++; $display("FAIL chirp_up_end timeout got BUSY=%b want 0", BUSY); end
    send_cmd(TIME + 64'd10, 48'd3, 48'd5, 32'd2, 16'd1, 2'd2, 32'd10, 32'd20, 32'd0, 32'd0);
    wait_imp(100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL chirp_dn_start timeout got IMP=%b want 1", IMP); end
    for (int k = 0; k < 6; k++) begin
      exp_f = 48'd3 - 48'(5 * (k / 2));
      checks++; if (FREQ_OUT !== exp_f) begin failures++; $display("FAIL chirp_dn k=%0d got %0h want %0h", k, FREQ_OUT, exp_f); end
      tick(1);
    end
    wait_idle(50, ok);
    checks++; if (!ok) begin failures++; $display("FAIL chirp_dn_end timeout got BUSY=%b want 0", BUSY); end
  endtask

  task automatic test_rejects;
    for (int c = 0; c < 3; c++) begin
      tick(12);
      err_seen = 0; imp_seen = 0; req_rises = 0;
      case (c)
        0: send_cmd(TIME - 64'd1, 48'd1, 48'd0, 32'd0, 16'd1, 2'd0, 32'd3, 32'd10, 32'd0, 32'd0);
        1: send_cmd(TIME + 64'd100, 48'd1, 48'd0, 32'd0, 16'd1, 2'd0, 32'd3, 32'd0, 32'd0, 32'd0);
        default: send_cmd(TIME + 64'd100, 48'd1, 48'd0, 32'd0, 16'd0, 2'd0, 32'd3, 32'd10, 32'd0, 32'd0);
      endcase
      tick(10);
      checks++; if (err_seen != 1) begin failures++; $display("FAIL reject%0d_err_pulses got %0d want 1", c, err_seen); end
      checks++; if (imp_seen != 0) begin failures++; $display("FAIL reject%0d_imp got %0d want 0", c, imp_seen); end
      checks++; if (req_rises == 0) begin failures++; $display("FAIL reject%0d_req got %0d rises want >=1", c, req_rises); end
      checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL reject%0d_busy got %b want 0", c, BUSY); end
    end
  endtask

  task automatic test_overwrite;
    bit ok;
    logic [63:0] a_start, c_start;
    tick(5);
    a_start = TIME + 64'd60;
    c_start = a_start + 64'd40;
    err_seen = 0;
    send_cmd(a_start, 48'd111, 48'd0, 32'd0, 16'd1, 2'd0, 32'd3, 32'd10, 32'd0, 32'd0);
    send_cmd(TIME + 64'd500, 48'd222, 48'd0, 32'd0, 16'd1, 2'd0, 32'd3, 32'd10, 32'd0, 32'd0);
    send_cmd(c_start, 48'd333, 48'd0, 32'd0, 16'd1, 2'd0, 32'd3, 32'd10, 32'd0, 32'd0);
    checks++; if (err_seen != 1) begin failures++; $display("FAIL ovw_err_pulses got %0d want 1", err_seen); end
    wait_imp(200, ok);
    checks++; if (!ok || FREQ_OUT !== 48'd111) begin failures++; $display("FAIL ovw_first_freq got %0d want 111", FREQ_OUT); end
    checks++; if (TIME !== a_start + 64'd1) begin failures++; $display("FAIL ovw_first_time got %0d want %0d", TIME, a_start + 64'd1); end
    wait_idle(50, ok);
    wait_imp(200, ok);
    checks++; if (!ok || FREQ_OUT !== 48'd333) begin failures++; $display("FAIL ovw_second_freq got %0d want 333", FREQ_OUT); end
    checks++; if (TIME !== c_start + 64'd1) begin failures++; $display("FAIL ovw_second_time got %0d want %0d", TIME, c_start + 64'd1); end
    wait_idle(50, ok);
    checks++; if (!ok) begin failures++; $display("FAIL ovw_end timeout got BUSY=%b want 0", BUSY); end
  endtask

  task automatic test_abort;
    bit ok;
    tick(5);
    send_cmd(TIME + 64'd20, 48'd900, 48'd0, 32'd0, 16'd5, 2'd0, 32'd5, 32'd20, 32'd2, 32'd3);
    send_cmd(TIME + 64'd200, 48'd44, 48'd0, 32'd0, 16'd1, 2'd0, 32'd5, 32'd20, 32'd0, 32'd0);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (IMP === 1'b1 && IMP_CNT === 16'd2) ok = 1'b1;
      else tick(1);
    end
    checks++; if (!ok) begin failures++; $display("FAIL abort_reach timeout got IMP_CNT=%0d want 2", IMP_CNT); end
    SYS_TIME_UPDATE = 1'b1;
    tick(2);
    checks++; if (IMP !== 1'b0 || BLANK !== 1'b0) begin failures++; $display("FAIL abort_gates got %b%b want 00", IMP, BLANK); end
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL abort_busy got %b want 0", BUSY); end
    checks++; if (REQ_COMM !== 1'b1) begin failures++; $display("FAIL abort_req got %b want 1", REQ_COMM); end
    tick(2);
    SYS_TIME_UPDATE = 1'b0;
    imp_seen = 0;
    tick(250);
    checks++; if (imp_seen != 0 || BUSY !== 1'b0) begin failures++; $display("FAIL abort_pending_cleared got imp=%0d busy=%b want 0 0", imp_seen, BUSY); end
    // Asynchronous reset in the middle of a burst.
    send_cmd(TIME + 64'd10, 48'd777, 48'd0, 32'd0, 16'd5, 2'd0, 32'd5, 32'd20, 32'd2, 32'd3);
    wait_imp(100, ok);
    tick(1);
    checks++; if (!ok || BUSY !== 1'b1) begin failures++; $display("FAIL arst_precond got busy=%b want 1", BUSY); end
    #2 rst = 1'b1;
    #1;
    checks++; if (IMP !== 1'b0 || BLANK !== 1'b0) begin failures++; $display("FAIL arst_gates got %b%b want 00", IMP, BLANK); end
    checks++; if (BUSY !== 1'b0 || REQ_COMM !== 1'b0) begin failures++; $display("FAIL arst_busy_req got %b%b want 00", BUSY, REQ_COMM); end
    checks++; if (FREQ_OUT !== 48'd0 || IMP_CNT !== 16'd0) begin failures++; $display("FAIL arst_regs got freq=%0d cnt=%0d want 0 0", FREQ_OUT, IMP_CNT); end
    tick(2);
    rst = 1'b0;
    tick(2);
  endtask

  initial begin
    rst = 1'b1; TIME = 64'd0; SYS_TIME_UPDATE = 1'b0; DATA_WR = 1'b0;
    FREQ_z = '0; FREQ_STEP_z = '0; FREQ_RATE_z = '0; TIME_START_z = '0; N_impuls_z = '0;
    TYPE_impulse_z = '0; Interval_Ti_z = '0; Interval_Tp_z = '0; Tblank1_z = '0; Tblank2_z = '0;
    test_reset();
    test_basic_burst();
    test_chirp();
    test_rejects();
    test_overwrite();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cmd_executor.md
Name: cmd_executor

Overview:
- Consumer end of the command-memory interface. Accepts commands pushed with DATA_WR and the *_z field bus, and holds one pending command in a shadow register.
- When the system time reaches TIME_START it executes the command as N impulse periods, producing IMP, BLANK and a per-cycle frequency word for the synthesizer.
- Pulls the next command from the writer with REQ_COMM.

Parameters:
- REQ_LEN, 4, REQ_COMM high time in CLK cycles (min 3; the writer edge-detects through a 3-stage shift).
- REQ_TIMEOUT, 4800, cycles to wait for DATA_WR before re-issuing REQ_COMM (100 µs at 48 MHz).

Ports:
- CLK  in  1  system clock, 48 MHz
- rst  in  1  asynchronous reset, active-high
- TIME  in  64  current system time, in CLK ticks
- SYS_TIME_UPDATE  in  1  system time was re-set; level, ≥3 cycles
- DATA_WR  in  1  command-valid strobe, 1+ cycles; rising edge used
- FREQ_z, FREQ_STEP_z  in  48 each  start frequency, frequency step
- FREQ_RATE_z  in  32  cycles between frequency steps
- TIME_START_z  in  64  absolute start time
- N_impuls_z  in  16  impulse count
- TYPE_impulse_z  in  2  0 = constant, 1 = chirp up, 2 = chirp down, 3 = treated as 0
- Interval_Ti_z, Interval_Tp_z  in  32 each  impulse width, period (ticks)
- Tblank1_z, Tblank2_z  in  32 each  blank after impulse, blank at end of period
- REQ_COMM  out  1  request next command
- IMP  out  1  impulse gate
- BLANK  out  1  receiver blanking
- FREQ_OUT  out  48  instantaneous frequency word
- BUSY  out  1  state ≠ IDLE
- IMP_CNT  out  16  impulses started in current command
- CMD_ERR  out  1  1-cycle pulse on rejected or overwritten command

Behaviour:

Reset:
- All outputs 0; state = IDLE; pending empty; request FSM in REQ_IDLE.
- Reset asserted mid-operation aborts at once and all outputs go low asynchronously.

Capture:
- On a DATA_WR rising edge (registered edge detect, so capture happens 1 cycle after the edge), all fields latch into pending and pend_valid = 1.
- If pend_valid was already 1, the new command overwrites it and CMD_ERR pulses.

Load:
- In IDLE with pend_valid = 1: pending is copied to active and pend_valid is cleared.
- The command is rejected (CMD_ERR pulse, stay IDLE) if any of these hold: TIME_START ≤ TIME, Interval_Tp = 0, or N = 0.
- Otherwise state goes to WAIT.

Exec FSM:
- IDLE→WAIT: on a valid load.
- WAIT→RUN: at the first edge where TIME ≥ TIME_START. On that edge: phase p = 0, IMP_CNT = 1, FREQ_OUT = FREQ, step counter = 0. IMP goes high on the same edge if Ti > 0, so IMP is 1 cycle after TIME first satisfies the condition.
- RUN:
  - p increments each cycle.
  - IMP = (p < Ti). If Ti ≥ Tp, IMP is 1 for the whole period.
  - BLANK = (p < Ti + Tblank1) OR (p ≥ Tp − Tblank2). Use 33-bit compares with saturating subtract, so no wrap.
  - When p = Tp−1: p returns to 0. If IMP_CNT = N, go to IDLE; otherwise IMP_CNT increments and FREQ_OUT reloads FREQ.
- Chirp (type 1 or 2, only while IMP = 1):
  - The step counter counts to FREQ_RATE−1, then FREQ_OUT ±= FREQ_STEP, modulo 2^48.
  - FREQ_RATE = 0 means a step every cycle.
  - Type 0: FREQ_OUT stays at FREQ.
- Return to IDLE: IMP = 0, BLANK = 0, FREQ_OUT holds its last value, IMP_CNT holds its value.

SYS_TIME_UPDATE:
- Detected on its rising edge.
- In WAIT: abort to IDLE and clear pending.
- In RUN: abort to IDLE (IMP and BLANK drop on the next edge) and clear pending.
- In all cases, force the request FSM into REQ_HIGH after the abort.

Request FSM:
- REQ_IDLE: if pend_valid = 0, go to REQ_HIGH.
- REQ_HIGH: REQ_COMM = 1 for REQ_LEN cycles, then go to REQ_WAIT.
- REQ_WAIT: the timeout counter runs.
  - A DATA_WR capture returns the FSM to REQ_IDLE.
  - If the count reaches REQ_TIMEOUT, go to REQ_LOW.
- REQ_LOW: REQ_COMM = 0 for 3 cycles, then go to REQ_HIGH.
- Between consecutive highs REQ_COMM is low for at least 3 cycles.

Simultaneous events:
- DATA_WR capture in the same cycle as a load: the load uses the old pending and the new data goes into pending. No CMD_ERR.
- SYS_TIME_UPDATE coincident with DATA_WR: the abort wins and the new data is discarded.
- TIME wrap: none is handled; TIME is 64-bit and monotonic except at SYS_TIME_UPDATE.

Test Plan:
1. Request after reset: release rst → REQ_COMM high for exactly 4 cycles. With no DATA_WR, it goes high again 4800+3 cycles after the first high ends.
2. Basic burst: TIME counting from 1000; load TIME_START=2000, N=3, Tp=100, Ti=10, Tblank1=5, Tblank2=8, type 0 → first IMP high 1 cycle after TIME=2000. IMP is high 10 cycles of every 100; BLANK is high for p<15 and p≥92. IMP_CNT ends at 3. BUSY falls 300 cycles after start.
3. Chirp: type 1, FREQ=1000, FREQ_STEP=5, FREQ_RATE=2, Ti=10 → FREQ_OUT sequence 1000,1000,1005,1005,1010,… within each impulse; reloads to 1000 at each period start. Same with type 2 and FREQ=3 → wraps to 2^48−2.
4. Rejects: TIME_START=TIME−1, Tp=0 or N=0 → CMD_ERR single pulse, IMP never asserts, REQ_COMM re-issued.
5. Overwrite: two DATA_WR while WAIT holds pending → one CMD_ERR; the second command is the one executed next.
6. Abort: SYS_TIME_UPDATE mid-RUN (IMP_CNT=2 of 5) → IMP and BLANK low on the next edge, BUSY=0, pending cleared, REQ_COMM high within 2 cycles. Async rst mid-RUN → all outputs 0 with no clock edge.
